// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants and types for the async FIFO read-side serializer.
//   FIFO_DSIZE      default FIFO word width (160)
//   RD_SER_OSIZE    default serializer beat width (32)
//   rd_ser_state_t  serializer FSM states (RS_IDLE / RS_SEND)
//   cnt_width()     beat counter width, never smaller than 1 bit
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DSIZE   = 160;
  localparam int RD_SER_OSIZE = 32;

  typedef enum logic {
    RS_IDLE,
    RS_SEND
  } rd_ser_state_t;

  // A single-beat configuration still needs a 1-bit counter to stay legal.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_serializer.sv
// ---------------------------------------------------------------------------
// fifo_rd_serializer
// Read-domain consumer of the async FIFO. Pops DSIZE-bit words from a
// first-word-fall-through read port and emits each one as DSIZE/OSIZE beats
// on a valid/ready stream, least-significant slice first. A new word is
// popped on the same cycle as the last beat's handshake, so back-to-back
// words stream without a bubble.
//
// Ports:
//   RCLK    in   read-domain clock, rising edge
//   RRST    in   synchronous active-high reset
//   RDATA   in   FIFO read data, valid while REMPTY==0
//   REMPTY  in   FIFO empty flag
//   RINC    out  FIFO pop, one pulse per consumed word
//   ODATA   out  current beat
//   OVALID  out  beat valid
//   OREADY  in   sink ready, transfer on OVALID && OREADY
//   OFIRST  out  beat 0 of a word
//   OLAST   out  final beat of a word
//   OPAR    out  even parity of ODATA (only with RD_SER_PARITY_EN)
//
// Build option: define RD_SER_PARITY_EN to add the OPAR output.
// ---------------------------------------------------------------------------
module fifo_rd_serializer
  import fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE,
  parameter int OSIZE = RD_SER_OSIZE
) (
  input  logic             RCLK,
  input  logic             RRST,
  input  logic [DSIZE-1:0] RDATA,
  input  logic             REMPTY,
  output logic             RINC,
  output logic [OSIZE-1:0] ODATA,
  output logic             OVALID,
  input  logic             OREADY,
  output logic             OFIRST,
`ifdef RD_SER_PARITY_EN
  output logic             OPAR,
`endif
  output logic             OLAST
);

  localparam int BEATS = DSIZE / OSIZE;
  localparam int CW    = cnt_width(BEATS);
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  // Word width must split evenly into beats; anything else is a wiring bug.
  if (DSIZE % OSIZE != 0) begin : g_bad_size
    $error("fifo_rd_serializer: DSIZE (%0d) is not a multiple of OSIZE (%0d)", DSIZE, OSIZE);
  end

  rd_ser_state_t state;
  rd_ser_state_t state_next;
  logic [CW-1:0]    cnt;
  logic [DSIZE-1:0] shreg;
  logic             pop;
  logic             handshake;
  logic             last_beat;
  logic [OSIZE-1:0] beat_data;

  // Next-state and output decode. Outputs come straight from the held word,
  // so a stalled beat stays stable for free. The pop is gated by reset so a
  // word presented during reset is left in the FIFO for the next start.
  always_comb begin
    state_next = state;
    beat_data  = '0;
    OVALID     = 1'b0;
    OFIRST     = 1'b0;
    OLAST      = 1'b0;
    last_beat  = (cnt == LAST_IDX);
    handshake  = (state == RS_SEND) && OREADY;

    if (state == RS_SEND) begin
      OVALID    = 1'b1;
      beat_data = shreg[OSIZE-1:0];
      OFIRST    = (cnt == '0);
      OLAST     = last_beat;
    end

    pop = ((state == RS_IDLE) || (handshake && last_beat)) && !REMPTY && !RRST;

    case (state)
      RS_IDLE: if (pop) state_next = RS_SEND;
      RS_SEND: if (handshake && last_beat && !pop) state_next = RS_IDLE;
      default: state_next = RS_IDLE;
    endcase

    RINC  = pop;
    ODATA = beat_data;
`ifdef RD_SER_PARITY_EN
    OPAR  = ^beat_data;
`endif
  end

  // State, beat counter and shift register. A pop always reloads the word
  // and restarts at beat 0; a mid-word handshake shifts the next slice down.
  always_ff @(posedge RCLK) begin
    if (RRST) begin
      state <= RS_IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        shreg <= RDATA;
        cnt   <= '0;
      end else if (handshake && !last_beat) begin
        shreg <= shreg >> OSIZE;
        cnt   <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_serializer
// Self-checking bench for fifo_rd_serializer (DSIZE=160, OSIZE=32). A queue
// stands in for the FIFO and a queue of pending beats models the serializer.
// Build option: RD_SER_PARITY_EN also checks OPAR.
// ---------------------------------------------------------------------------
module tb_fifo_rd_serializer;

  localparam int DSIZE = 160;
  localparam int OSIZE = 32;
  localparam int BEATS = DSIZE / OSIZE;
  localparam logic [DSIZE-1:0] W1 = {32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
  localparam logic [DSIZE-1:0] W2 = W1 << 4;

  logic             RCLK = 1'b0;
  logic             RRST;
  logic [DSIZE-1:0] RDATA;
  logic             REMPTY;
  logic             RINC;
  logic [OSIZE-1:0] ODATA;
  logic             OVALID;
  logic             OREADY;
  logic             OFIRST;
  logic             OLAST;
`ifdef RD_SER_PARITY_EN
  logic             OPAR;
`endif

  always #5 RCLK = ~RCLK;

  fifo_rd_serializer #(.DSIZE(DSIZE), .OSIZE(OSIZE)) dut (
    .RCLK   (RCLK),
    .RRST   (RRST),
    .RDATA  (RDATA),
    .REMPTY (REMPTY),
    .RINC   (RINC),
    .ODATA  (ODATA),
    .OVALID (OVALID),
    .OREADY (OREADY),
    .OFIRST (OFIRST),
`ifdef RD_SER_PARITY_EN
    .OPAR   (OPAR),
`endif
    .OLAST  (OLAST)
  );

  int               tests = 0;
  int               failures = 0;
  int               cycle_no = 0;
  int               rinc_cnt = 0;
  bit               check_zero = 1'b0;
  logic [DSIZE-1:0] fifo_q[$];
  logic [OSIZE-1:0] beats_q[$];
  logic [OSIZE-1:0] delivered[$];
  int               hs_cycle[$];
  logic [OSIZE-1:0] exp_seq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    REMPTY = (fifo_q.size() == 0);
    RDATA  = REMPTY ? '0 : fifo_q[0];
  endtask

  task automatic apply_stimulus(input logic rst, input logic rdy);
    RRST   = rst;
    OREADY = rdy;
    drive_fifo();
  endtask

  // Compare against the beat-queue model, then advance the model by one cycle.
  task automatic check_output(output logic popped);
    logic             exp_valid;
    logic             exp_rinc;
    logic [DSIZE-1:0] word;
    exp_valid = (beats_q.size() != 0);
    exp_rinc  = !RRST && (fifo_q.size() != 0) &&
                (!exp_valid || (OREADY && beats_q.size() == 1));
    check("rinc", 32'(RINC), 32'(exp_rinc));
    check("ovalid", 32'(OVALID), 32'(exp_valid));
    if (exp_valid) begin
      check("odata", ODATA, beats_q[0]);
      check("ofirst", 32'(OFIRST), 32'(beats_q.size() == BEATS));
      check("olast", 32'(OLAST), 32'(beats_q.size() == 1));
`ifdef RD_SER_PARITY_EN
      check("opar", 32'(OPAR), 32'(^beats_q[0]));
`endif
    end
    if (check_zero) check("odata_zero", ODATA, 32'h0);
    if (RINC) rinc_cnt++;
    if (exp_valid && OREADY && !RRST) begin
      delivered.push_back(beats_q[0]);
      hs_cycle.push_back(cycle_no);
    end
    if (RRST) begin
      beats_q.delete();
    end else begin
      if (exp_valid && OREADY) void'(beats_q.pop_front());
      if (exp_rinc) begin
        word = fifo_q[0];
        for (int b = 0; b < BEATS; b++) beats_q.push_back(word[b*OSIZE +: OSIZE]);
      end
    end
    popped = exp_rinc;
  endtask

  task automatic step();
    logic popped;
    @(negedge RCLK);
    check_output(popped);
    @(posedge RCLK);
    #1;
    if (popped) void'(fifo_q.pop_front());
    drive_fifo();
    cycle_no++;
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b0, rdy);
      step();
    end
  endtask

  task automatic clear_capture();
    delivered.delete();
    hs_cycle.delete();
    rinc_cnt = 0;
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_count"}, 32'(delivered.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size(); i++)
      check(tag, (i < delivered.size()) ? delivered[i] : 32'hxxxxxxxx, exp_seq[i]);
  endtask

  initial begin
    logic [DSIZE-1:0] rnd;

    // Bring the DUT to a known state before any checking.
    fifo_q.delete();
    apply_stimulus(1'b1, 1'b0);
    @(posedge RCLK);
    #1;

    // Test 1: reset held with a word waiting; nothing may pop or appear.
    fifo_q.push_back(W1);
    check_zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b1);
      step();
    end
    check_zero = 1'b0;
    check("t1_fifo_untouched", 32'(fifo_q.size()), 32'd1);

    // Test 2: the waiting word streams out as five beats.
    clear_capture();
    run(8, 1'b1);
    exp_seq = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    check_seq("t2_beats");
    check("t2_rinc_cnt", 32'(rinc_cnt), 32'd1);
    check("t2_contiguous", (hs_cycle.size() == 5) ? 32'(hs_cycle[4] - hs_cycle[0]) : 32'hffffffff, 32'd4);

    // Test 3: two queued words stream back to back with no gap.
    clear_capture();
    fifo_q.push_back(W1);
    fifo_q.push_back(W2);
    run(13, 1'b1);
    exp_seq = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
    check_seq("t3_beats");
    check("t3_rinc_cnt", 32'(rinc_cnt), 32'd2);
    check("t3_no_gap", (hs_cycle.size() == 10) ? 32'(hs_cycle[9] - hs_cycle[0]) : 32'hffffffff, 32'd9);

    // Test 4: sink stalls for four cycles while beat 3 is presented.
    clear_capture();
    fifo_q.push_back(W1);
    run(3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b0);
      check("t4_stall_odata", ODATA, 32'h3);
      check("t4_stall_ovalid", 32'(OVALID), 32'd1);
      step();
    end
    run(5, 1'b1);
    exp_seq = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    check_seq("t4_beats");
    check("t4_rinc_cnt", 32'(rinc_cnt), 32'd1);

    // Test 5: reset lands on beat 2; the rest of W1 is dropped, W2 starts clean.
    clear_capture();
    fifo_q.push_back(W1);
    fifo_q.push_back(W2);
    run(2, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    step();
    run(8, 1'b1);
    exp_seq = {32'h1, 32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
    check_seq("t5_beats");
    check("t5_rinc_cnt", 32'(rinc_cnt), 32'd2);

    // Random traffic: bursty words, a flaky sink and the occasional reset.
    for (int i = 0; i < 400; i++) begin
      if (fifo_q.size() < 3 && $urandom_range(0, 2) == 0) begin
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
        fifo_q.push_back(rnd);
      end
      apply_stimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
      step();
    end
    run(20, 1'b1);
    check("drain_idle", 32'(OVALID), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
